// File: rtl/prt_dp_rx_sdp_buf_pkg.sv
// Shared constants, register map and FSM type for the DP RX SDP buffer.
package prt_dp_rx_sdp_buf_pkg;

  localparam int unsigned DAT_WIDTH = 32;

  // Local bus register word indices.
  localparam logic [3:0] REG_CTL  = 4'd0;
  localparam logic [3:0] REG_STA  = 4'd1;
  localparam logic [3:0] REG_LEN  = 4'd2;
  localparam logic [3:0] REG_DAT  = 4'd3;
  localparam logic [3:0] REG_FILT = 4'd4;

  // CTL bit positions.
  localparam int unsigned CTL_RUN    = 0;
  localparam int unsigned CTL_CLR    = 1;
  localparam int unsigned CTL_IRQ_EN = 2;

  // STA bit positions; [4:0] carries the pending count.
  localparam int unsigned STA_CNT_W = 5;
  localparam int unsigned STA_OVF   = 8;
  localparam int unsigned STA_TRUNC = 9;
  localparam int unsigned STA_ABORT = 10;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    DROP
  } wr_state_t;

  // Ceiling log2, never less than 1 bit.
  function automatic int unsigned log2c(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Address width of the whole slot buffer: slot index concatenated with word index.
  function automatic int unsigned slot_adr_width(input int unsigned pkts, input int unsigned words);
    return log2c(pkts) + log2c(words);
  endfunction

endpackage

// File: rtl/prt_dp_lb_if.sv
// Local bus register access port.
interface prt_dp_lb_if #(
  parameter int unsigned P_ADR_WIDTH = 32
);
  logic [P_ADR_WIDTH-1:0] adr;
  logic                   wr;
  logic                   rd;
  logic [31:0]            din;
  logic [31:0]            dout;
  logic                   vld;

  modport lb_in  (input adr, wr, rd, din, output dout, vld);
  modport lb_out (output adr, wr, rd, din, input dout, vld);
endinterface

// File: rtl/prt_dp_rx_sdp_if.sv
// SDP word stream from the RX link extractor.
interface prt_dp_rx_sdp_if;
  logic        sop;
  logic        eop;
  logic [31:0] dat;
  logic        vld;

  modport snk (input sop, eop, dat, vld);
  modport src (output sop, eop, dat, vld);
endinterface

// File: rtl/prt_dp_rx_sdp_buf_ram.sv
// Simple dual-port packet RAM with a registered 1-cycle read.
module prt_dp_rx_sdp_buf_ram #(
  parameter int unsigned P_AW = 6,
  parameter int unsigned P_DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [P_AW-1:0] wadr,
  input  logic [P_DW-1:0] wdat,
  input  logic            re,
  input  logic [P_AW-1:0] radr,
  output logic [P_DW-1:0] rdat
);

  localparam int unsigned DEPTH = 2 ** P_AW;

  logic [P_DW-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[wadr] <= wdat;
  end

  // Read port; data appears the cycle after the address.
  always_ff @(posedge clk) begin
    if (re) rdat <= mem[radr];
  end

endmodule

// File: rtl/prt_dp_rx_sdp_buf.sv
// DP RX SDP sink buffer: stores complete SDPs in P_PKTS slots and serves them
// to the policy processor over the local bus with a pending-packet interrupt.
// Optional header filter register enabled by `define PRT_DP_RX_SDP_BUF_FILTER_EN.
module prt_dp_rx_sdp_buf
  import prt_dp_rx_sdp_buf_pkg::*;
#(
  parameter int unsigned P_PKTS         = 4,
  parameter int unsigned P_SLOT_WORDS   = 16,
  parameter int unsigned P_LB_ADR_WIDTH = 32
) (
  input  logic              CLK_IN,
  input  logic              RST_IN,
  prt_dp_rx_sdp_if.snk      SDP_IF,
  prt_dp_lb_if.lb_in        LB_IF,
  output logic              IRQ_OUT
);

  localparam int unsigned PW = log2c(P_PKTS);
  localparam int unsigned WW = log2c(P_SLOT_WORDS);
  localparam int unsigned AW = slot_adr_width(P_PKTS, P_SLOT_WORDS);
  localparam int unsigned LW = WW + 1;
  localparam int unsigned CW = PW + 1;

  wr_state_t         state_q, state_d;
  logic [LW-1:0]     cnt_q, cnt_d, cnt_inc_c;
  logic [PW-1:0]     wp_q, rp_q;
  logic [WW-1:0]     idx_q;
  logic [CW-1:0]     count_q;
  logic [LW-1:0]     len_q [P_PKTS];
  logic              run_q, irq_en_q;
  logic              ovf_q, trunc_q, abort_q;

  logic              we_c, commit_c, start_c;
  logic [WW-1:0]     wword_c;
  logic [LW-1:0]     clen_c;
  logic              set_ovf_c, set_trunc_c, set_abort_c;
  logic              full_c, empty_c, filt_rej_c;

  logic [3:0]        ridx_c;
  logic              wr_ctl_c, clr_c, pop_c, last_c, free_c;
  logic [31:0]       rdata_c;
  logic              rd_q, pop_q;
  logic [31:0]       rdata_q;
  logic [31:0]       ram_rdat;
  logic              unused_c;

  assign ridx_c    = LB_IF.adr[3:0];
  assign wr_ctl_c  = LB_IF.wr && (ridx_c == REG_CTL);
  assign clr_c     = wr_ctl_c && LB_IF.din[CTL_CLR];
  assign full_c    = (count_q == CW'(P_PKTS));
  assign empty_c   = (count_q == '0);
  assign pop_c     = LB_IF.rd && (ridx_c == REG_DAT) && !empty_c && !clr_c;
  assign last_c    = ((LW'(idx_q) + LW'(1)) == len_q[rp_q]);
  assign free_c    = pop_c && last_c;
  assign cnt_inc_c = (cnt_q < LW'(P_SLOT_WORDS)) ? (cnt_q + LW'(1)) : cnt_q;
  assign unused_c  = ^{LB_IF.adr[P_LB_ADR_WIDTH-1:4], LB_IF.din};

`ifdef PRT_DP_RX_SDP_BUF_FILTER_EN
  logic [7:0] filt_type_q;
  logic       filt_en_q;

  assign filt_rej_c = filt_en_q && (SDP_IF.dat[15:8] != filt_type_q);

  // Header-type filter register.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      filt_type_q <= '0;
      filt_en_q   <= 1'b0;
    end else if (LB_IF.wr && (ridx_c == REG_FILT)) begin
      filt_type_q <= LB_IF.din[7:0];
      filt_en_q   <= LB_IF.din[8];
    end
  end
`else
  assign filt_rej_c = 1'b0;
`endif

  // Write FSM state register; clr aborts any packet in flight silently.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || clr_c) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write FSM next state, RAM write strobe and commit/flag requests.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_c        = 1'b0;
    wword_c     = '0;
    commit_c    = 1'b0;
    clen_c      = '0;
    set_ovf_c   = 1'b0;
    set_trunc_c = 1'b0;
    set_abort_c = 1'b0;
    start_c     = 1'b0;

    if (SDP_IF.vld) begin
      case (state_q)
        WR: begin
          if (SDP_IF.sop) begin
            set_abort_c = 1'b1;
            start_c     = 1'b1;
          end else begin
            if (cnt_q < LW'(P_SLOT_WORDS)) begin
              we_c    = 1'b1;
              wword_c = cnt_q[WW-1:0];
            end else begin
              set_trunc_c = 1'b1;
            end
            cnt_d = cnt_inc_c;
            if (SDP_IF.eop) begin
              commit_c = 1'b1;
              clen_c   = cnt_inc_c;
              cnt_d    = '0;
              state_d  = IDLE;
            end
          end
        end
        DROP: begin
          if (SDP_IF.sop)      start_c = 1'b1;
          else if (SDP_IF.eop) state_d = IDLE;
        end
        default: begin
          if (SDP_IF.sop) start_c = 1'b1;
        end
      endcase
    end

    // A new sop restarts at word 0 of slot wp, or is dropped.
    if (start_c) begin
      cnt_d = '0;
      if (!run_q) begin
        state_d = IDLE;
      end else if (filt_rej_c) begin
        state_d = SDP_IF.eop ? IDLE : DROP;
      end else if (full_c) begin
        set_ovf_c = 1'b1;
        state_d   = SDP_IF.eop ? IDLE : DROP;
      end else begin
        we_c    = 1'b1;
        wword_c = '0;
        if (SDP_IF.eop) begin
          commit_c = 1'b1;
          clen_c   = LW'(1);
          state_d  = IDLE;
        end else begin
          cnt_d   = LW'(1);
          state_d = WR;
        end
      end
    end
  end

  // Slot pointers, read index and pending count.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || clr_c) begin
      wp_q    <= '0;
      rp_q    <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      if (commit_c) wp_q <= wp_q + PW'(1);
      if (pop_c) begin
        if (last_c) begin
          idx_q <= '0;
          rp_q  <= rp_q + PW'(1);
        end else begin
          idx_q <= idx_q + WW'(1);
        end
      end
      count_q <= count_q + CW'(commit_c) - CW'(free_c);
    end
  end

  // Length table, written on commit.
  always_ff @(posedge CLK_IN) begin
    if (commit_c) len_q[wp_q] <= clen_c;
  end

  // CTL run and irq_en bits; clr is a write strobe and is not stored.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      run_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else if (wr_ctl_c) begin
      run_q    <= LB_IF.din[CTL_RUN];
      irq_en_q <= LB_IF.din[CTL_IRQ_EN];
    end
  end

  // Sticky status flags.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN || clr_c) begin
      ovf_q   <= 1'b0;
      trunc_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      if (set_ovf_c)   ovf_q   <= 1'b1;
      if (set_trunc_c) trunc_q <= 1'b1;
      if (set_abort_c) abort_q <= 1'b1;
    end
  end

  prt_dp_rx_sdp_buf_ram #(
    .P_AW (AW),
    .P_DW (DAT_WIDTH)
  ) u_ram (
    .clk  (CLK_IN),
    .we   (we_c),
    .wadr ({wp_q, wword_c}),
    .wdat (SDP_IF.dat),
    .re   (pop_c),
    .radr ({rp_q, idx_q}),
    .rdat (ram_rdat)
  );

  // Register read mux for the non-RAM registers.
  always_comb begin
    rdata_c = '0;
    case (ridx_c)
      REG_CTL: rdata_c = 32'({irq_en_q, 1'b0, run_q});
      REG_STA: begin
        rdata_c[STA_CNT_W-1:0] = STA_CNT_W'(count_q);
        rdata_c[STA_OVF]       = ovf_q;
        rdata_c[STA_TRUNC]     = trunc_q;
        rdata_c[STA_ABORT]     = abort_q;
      end
      REG_LEN: rdata_c = empty_c ? 32'd0 : 32'(len_q[rp_q]);
`ifdef PRT_DP_RX_SDP_BUF_FILTER_EN
      REG_FILT: rdata_c = 32'({filt_en_q, filt_type_q});
`endif
      default: rdata_c = '0;
    endcase
  end

  // Read stage 1: capture request and register value alongside the RAM read.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      rd_q    <= 1'b0;
      pop_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_q    <= LB_IF.rd;
      pop_q   <= pop_c;
      rdata_q <= LB_IF.rd ? rdata_c : 32'd0;
    end
  end

  // Read stage 2: bus response, dout held at zero outside vld.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      LB_IF.vld  <= 1'b0;
      LB_IF.dout <= '0;
    end else begin
      LB_IF.vld  <= rd_q;
      LB_IF.dout <= !rd_q ? 32'd0 : (pop_q ? ram_rdat : rdata_q);
    end
  end

  // Level interrupt while packets are pending.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) IRQ_OUT <= 1'b0;
    else        IRQ_OUT <= irq_en_q && !empty_c;
  end

endmodule

// File: tb/tb_prt_dp_rx_sdp_buf.sv
// Directed self-checking bench for prt_dp_rx_sdp_buf (P_PKTS=4, P_SLOT_WORDS=16).
module tb_prt_dp_rx_sdp_buf;

  logic clk = 1'b0;
  logic rst;
  logic irq;
  int   n_cmp = 0;
  int   n_err = 0;

  prt_dp_rx_sdp_if sdp_if ();
  prt_dp_lb_if #(.P_ADR_WIDTH(32)) lb_if ();

  prt_dp_rx_sdp_buf #(
    .P_PKTS         (4),
    .P_SLOT_WORDS   (16),
    .P_LB_ADR_WIDTH (32)
  ) dut (
    .CLK_IN  (clk),
    .RST_IN  (rst),
    .SDP_IF  (sdp_if),
    .LB_IF   (lb_if),
    .IRQ_OUT (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] hdr_of(input logic [7:0] tag);
    return 32'h0083_0000 | 32'(tag);
  endfunction

  // Word i of a packet: header for i=0, otherwise tag/marker/index.
  function automatic logic [31:0] pw(input logic [31:0] hdr, input int i);
    return (i == 0) ? hdr : {hdr[7:0], 8'hA5, 16'(i)};
  endfunction

  task automatic lb_write(input logic [3:0] a, input logic [31:0] d);
    lb_if.adr = 32'(a);
    lb_if.din = d;
    lb_if.wr  = 1'b1;
    tick();
    lb_if.wr  = 1'b0;
  endtask

  task automatic lb_read(input logic [3:0] a, output logic [31:0] d);
    int lat;
    lb_if.adr = 32'(a);
    lb_if.rd  = 1'b1;
    tick();
    lb_if.rd  = 1'b0;
    lat = 1;
    while (lb_if.vld !== 1'b1 && lat < 8) begin
      tick();
      lat++;
    end
    d = lb_if.dout;
    chk("rd_lat", 32'(lat), 32'd2);
    tick();
    chk("vld_pulse", 32'(lb_if.vld), 32'd0);
    chk("dout_idle", lb_if.dout, 32'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    lb_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic send_pkt(input logic [31:0] hdr, input int n, input bit eop_en);
    for (int i = 0; i < n; i++) begin
      sdp_if.vld = 1'b1;
      sdp_if.sop = (i == 0);
      sdp_if.eop = eop_en && (i == n - 1);
      sdp_if.dat = pw(hdr, i);
      tick();
    end
    sdp_if.vld = 1'b0;
    sdp_if.sop = 1'b0;
    sdp_if.eop = 1'b0;
  endtask

  task automatic read_pkt(input string tag, input logic [31:0] hdr, input int n);
    logic [31:0] d;
    lb_read(4'd2, d);
    chk({tag, "_len"}, d, 32'(n));
    for (int i = 0; i < n; i++) begin
      lb_read(4'd3, d);
      chk({tag, "_dat"}, d, pw(hdr, i));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    sdp_if.vld = 1'b0;
    sdp_if.sop = 1'b0;
    sdp_if.eop = 1'b0;
    sdp_if.dat = '0;
    lb_if.adr  = '0;
    lb_if.wr   = 1'b0;
    lb_if.rd   = 1'b0;
    lb_if.din  = '0;
    repeat (3) tick();
    chk("rst_dout", lb_if.dout, 32'd0);
    chk("rst_vld", 32'(lb_if.vld), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    tick();
    rd_chk("rst_sta", 4'd1, 32'd0);
    rd_chk("rst_ctl", 4'd0, 32'd0);
    rd_chk("rst_len", 4'd2, 32'd0);

    // Single 9-word packet with interrupt.
    lb_write(4'd0, 32'h5);
    rd_chk("ctl_rb", 4'd0, 32'h5);
    send_pkt(32'h0083_0000, 9, 1'b1);
    tick();
    chk("t1_irq", 32'(irq), 32'd1);
    rd_chk("t1_sta", 4'd1, 32'h1);
    read_pkt("t1", 32'h0083_0000, 9);
    chk("t1_irq_off", 32'(irq), 32'd0);
    rd_chk("t1_sta_e", 4'd1, 32'h0);
    rd_chk("empty_dat", 4'd3, 32'h0);

    // Five back-to-back packets into four slots.
    for (int k = 0; k < 5; k++) send_pkt(hdr_of(8'(8'h10 + k)), 9, 1'b1);
    rd_chk("t2_sta", 4'd1, 32'h104);
    for (int k = 0; k < 4; k++) read_pkt("t2", hdr_of(8'(8'h10 + k)), 9);
    rd_chk("t2_sta_e", 4'd1, 32'h100);
    rd_chk("t2_len_e", 4'd2, 32'h0);
    lb_write(4'd0, 32'h7);
    rd_chk("t2_clr_sta", 4'd1, 32'h0);
    rd_chk("clr_self", 4'd0, 32'h5);

    // 20-word packet truncates to 16.
    send_pkt(hdr_of(8'h20), 20, 1'b1);
    rd_chk("t3_sta", 4'd1, 32'h201);
    read_pkt("t3", hdr_of(8'h20), 16);
    rd_chk("t3_sta_e", 4'd1, 32'h200);
    lb_write(4'd0, 32'h7);

    // Aborted partial packet followed by a complete one.
    send_pkt(hdr_of(8'h30), 5, 1'b0);
    send_pkt(hdr_of(8'h31), 9, 1'b1);
    rd_chk("t4_sta", 4'd1, 32'h401);
    read_pkt("t4", hdr_of(8'h31), 9);
    lb_write(4'd0, 32'h7);

    // clr mid-packet with two pending, then stray words and a fresh packet.
    send_pkt(hdr_of(8'h40), 9, 1'b1);
    send_pkt(hdr_of(8'h41), 9, 1'b1);
    send_pkt(hdr_of(8'h42), 4, 1'b0);
    lb_write(4'd0, 32'h7);
    rd_chk("t5_sta", 4'd1, 32'h0);
    rd_chk("t5_len", 4'd2, 32'h0);
    chk("t5_irq", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) begin
      sdp_if.vld = 1'b1;
      sdp_if.sop = 1'b0;
      sdp_if.eop = (i == 2);
      sdp_if.dat = 32'hDEAD_0000 | 32'(i);
      tick();
    end
    sdp_if.vld = 1'b0;
    sdp_if.eop = 1'b0;
    rd_chk("t5_stray", 4'd1, 32'h0);
    send_pkt(hdr_of(8'h43), 9, 1'b1);
    rd_chk("t5_sta2", 4'd1, 32'h1);
    read_pkt("t5", hdr_of(8'h43), 9);

    // run=0 ignores the stream.
    lb_write(4'd0, 32'h4);
    send_pkt(hdr_of(8'h50), 9, 1'b1);
    rd_chk("t6_sta", 4'd1, 32'h0);
    chk("t6_irq", 32'(irq), 32'd0);

    // Single-word packet with irq_en=0.
    lb_write(4'd0, 32'h1);
    send_pkt(hdr_of(8'h60), 1, 1'b1);
    tick();
    chk("t7_irq", 32'(irq), 32'd0);
    rd_chk("t7_sta", 4'd1, 32'h1);
    read_pkt("t7", hdr_of(8'h60), 1);

    // Unmapped accesses.
    lb_write(4'd9, 32'hFFFF_FFFF);
    rd_chk("unmapped", 4'd9, 32'h0);
    rd_chk("ctl_keep", 4'd0, 32'h1);

`ifdef PRT_DP_RX_SDP_BUF_FILTER_EN
    lb_write(4'd4, 32'h183);
    rd_chk("filt_rb", 4'd4, 32'h183);
    send_pkt(32'h0000_8470, 9, 1'b1);
    send_pkt(32'h0000_8371, 9, 1'b1);
    send_pkt(32'h0000_8472, 1, 1'b1);
    rd_chk("filt_sta", 4'd1, 32'h1);
    read_pkt("filt", 32'h0000_8371, 9);
`else
    lb_write(4'd4, 32'h183);
    rd_chk("filt_none", 4'd4, 32'h0);
    send_pkt(32'h0000_8470, 9, 1'b1);
    rd_chk("nofilt_sta", 4'd1, 32'h1);
    read_pkt("nofilt", 32'h0000_8470, 9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
